mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, SRAM word-address width.
REQ-002 Parameter RD_LAT, default 1, legal 1..3; cycles from SRAM command cycle to sram_dout valid.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  fetch read request, held until if_gnt.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  one-cycle pulse, if_rdata valid.
REQ-009 if_rdata  output  32  fetched word.
REQ-010 dm_req  input  1  data request, held until dm_gnt.
REQ-011 dm_we  input  4  byte write enables; 0 = read.
REQ-012 dm_addr  input  32  data byte address.
REQ-013 dm_wdata  input  32  write data.
REQ-014 dm_gnt  output  1  data request accepted this cycle.
REQ-015 dm_rvalid  output  1  one-cycle pulse, dm_rdata valid (reads only).
REQ-016 dm_rdata  output  32  loaded word.
REQ-017 sram_cs  output  1  SRAM chip select, registered.
REQ-018 sram_we  output  4  SRAM byte write enables, registered.
REQ-019 sram_addr  output  ADDR_W  SRAM word address, registered.
REQ-020 sram_din  output  32  SRAM write data, registered.
REQ-021 sram_dout  input  32  SRAM read data.
REQ-022 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-023 FSM states IDLE, CMD, WAIT; one transaction outstanding at most.
REQ-024 Grants issued only in IDLE: x_gnt = x_req & winner==x & state==IDLE & ~rst (combinational).
REQ-025 Single requester wins immediately; both requesting: round-robin, winner = requester not granted last; pointer favors IF after reset.
REQ-026 Grant cycle G: sample address/we/wdata; sram_addr = addr[ADDR_W+1:2] (low two bits dropped); fetch drives sram_we=0.
REQ-027 Cycle G+1 = CMD: sram_cs=1 with sampled command; all other cycles sram_cs=0, sram_we=0.
REQ-028 Write (dm_we!=0): CMD -> IDLE; next grant possible at G+2; no rvalid.
REQ-029 Read: CMD -> WAIT; down-counter loaded RD_LAT-1; capture sram_dout at end of cycle G+1+RD_LAT; owner's rvalid=1 with captured data at G+2+RD_LAT; FSM in IDLE that cycle, new grant allowed same cycle.
REQ-030 rvalid routed only to the requester that owned the transaction; other rvalid stays 0.
REQ-031 *_rdata hold last captured value between pulses.
REQ-032 Request dropped before grant: no transaction, pointer unchanged.
REQ-033 Requests arriving while busy wait; no loss, no duplicate grant.

Reset
REQ-034 rst=1 at a rising edge: state=IDLE, counter=0, pointer favors IF, all outputs 0, including rdata.
REQ-035 Reset during CMD/WAIT discards transaction; no rvalid afterwards.
REQ-036 Gnt outputs forced 0 while rst=1.

Structure
REQ-037 Package mem_arb_pkg holds state enum (IDLE/CMD/WAIT) and owner enum (OWN_IF/OWN_DM).
REQ-038 One sub-module rr_arb2: two-request round-robin with registered last-winner bit, update enable on grant.
REQ-039 All sram_* outputs driven from flops.

Verification
REQ-040 RD_LAT=1, if_req, if_addr=0x0000_0010 -> if_gnt at G, sram_cs/sram_addr=4 at G+1, if_rvalid with sram_dout at G+3.
REQ-041 dm_req write dm_we=4'b0011, dm_addr=0x20, dm_wdata=0xDEADBEEF -> sram_we=0011, addr=8, din=DEADBEEF at G+1; no dm_rvalid; next grant at G+2.
REQ-042 if_req and dm_req held continuously after reset -> grants alternate IF, DM, IF, DM; no starvation.
REQ-043 RD_LAT=3, DM read -> busy G+1..G+4, dm_rvalid at G+5, if_rvalid stays 0.
REQ-044 rst asserted in WAIT -> next cycle all outputs 0, no rvalid; IF granted first after release.
REQ-045 if_req pulsed one cycle while busy then dropped -> no if_gnt, no SRAM access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data SRAM arbiter: controller states and
// the identity of the requester that owns the outstanding transaction.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. The last-winner bit only moves when a
// grant is actually issued, so a request that vanishes ungranted leaves it alone.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   reqIf_i,
  input  logic   reqDm_i,
  input  logic   update_i,
  output owner_e winner_o
);

  logic lastDm_q, lastDm_d;

  always_comb begin
    winner_o = OWN_IF;
    if (reqIf_i && reqDm_i) begin
      winner_o = lastDm_q ? OWN_IF : OWN_DM;
    end else if (reqDm_i) begin
      winner_o = OWN_DM;
    end
    lastDm_d = lastDm_q;
    if (update_i) begin
      lastDm_d = (winner_o == OWN_DM);
    end
  end

  // Coming out of reset as if DM won last makes IF the favoured requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastDm_q <= 1'b1;
    end else begin
      lastDm_q <= lastDm_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported SRAM with a
// fixed read latency, keeping at most one transaction in flight.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              sram_cs,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  input  logic [31:0]       sram_dout,
  output logic              busy
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            winner;
  logic [1:0]        cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              ifRvalid_q, ifRvalid_d, dmRvalid_q, dmRvalid_d;
  logic [31:0]       ifRdata_q, ifRdata_d, dmRdata_q, dmRdata_d;
  logic              ifGnt, dmGnt, anyGnt;
  logic              unusedAddrBits;

  rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .reqIf_i  (if_req),
    .reqDm_i  (dm_req),
    .update_i (anyGnt),
    .winner_o (winner)
  );

  assign ifGnt  = if_req & (winner == OWN_IF) & (state_q == IDLE) & ~rst;
  assign dmGnt  = dm_req & (winner == OWN_DM) & (state_q == IDLE) & ~rst;
  assign anyGnt = ifGnt | dmGnt;

  // Only the word-address bits reach the SRAM; the rest are deliberately dropped.
  assign unusedAddrBits = ^{if_addr, dm_addr};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    cs_d       = 1'b0;
    we_d       = 4'b0000;
    addr_d     = addr_q;
    din_d      = din_q;
    ifRvalid_d = 1'b0;
    dmRvalid_d = 1'b0;
    ifRdata_d  = ifRdata_q;
    dmRdata_d  = dmRdata_q;
    unique case (state_q)
      IDLE: begin
        if (anyGnt) begin
          state_d = CMD;
          cs_d    = 1'b1;
          if (dmGnt) begin
            owner_d = OWN_DM;
            we_d    = dm_we;
            addr_d  = dm_addr[ADDR_W+1:2];
            din_d   = dm_wdata;
          end else begin
            owner_d = OWN_IF;
            addr_d  = if_addr[ADDR_W+1:2];
          end
        end
      end
      CMD: begin
        if (we_q != 4'b0000) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        // Counter reaching zero marks the cycle sram_dout is valid.
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) begin
            ifRvalid_d = 1'b1;
            ifRdata_d  = sram_dout;
          end else begin
            dmRvalid_d = 1'b1;
            dmRdata_d  = sram_dout;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= 2'd0;
      cs_q       <= 1'b0;
      we_q       <= 4'b0000;
      addr_q     <= '0;
      din_q      <= 32'h0;
      ifRvalid_q <= 1'b0;
      dmRvalid_q <= 1'b0;
      ifRdata_q  <= 32'h0;
      dmRdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ifRvalid_q <= ifRvalid_d;
      dmRvalid_q <= dmRvalid_d;
      ifRdata_q  <= ifRdata_d;
      dmRdata_q  <= dmRdata_d;
    end
  end

  assign if_gnt    = ifGnt;
  assign dm_gnt    = dmGnt;
  assign if_rvalid = ifRvalid_q;
  assign if_rdata  = ifRdata_q;
  assign dm_rvalid = dmRvalid_q;
  assign dm_rdata  = dmRdata_q;
  assign sram_cs   = cs_q;
  assign sram_we   = we_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one instance at read latency 1 and one
// at latency 3, each behind a small SRAM model, with a read-data scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;

  logic        ifReq, ifGnt, ifRvalid, dmReq, dmGnt, dmRvalid;
  logic [31:0] ifAddr, ifRdata, dmAddr, dmWdata, dmRdata;
  logic [3:0]  dmWe, sramWe;
  logic        sramCs, busy;
  logic [13:0] sramAddr;
  logic [31:0] sramDin, sramDout;

  logic        ifReqB, ifGntB, ifRvalidB, dmReqB, dmGntB, dmRvalidB;
  logic [31:0] ifAddrB, ifRdataB, dmAddrB, dmWdataB, dmRdataB;
  logic [3:0]  dmWeB, sramWeB;
  logic        sramCsB, busyB;
  logic [13:0] sramAddrB;
  logic [31:0] sramDinB, sramDoutB;

  logic [31:0] ifQ[$], dmQ[$], ifQB[$], dmQB[$];
  logic [32:0] rdA = '0;
  logic [32:0] rdB0 = '0, rdB1 = '0, rdB2 = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(14), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_gnt(ifGnt), .if_rvalid(ifRvalid), .if_rdata(ifRdata),
    .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata), .dm_gnt(dmGnt),
    .dm_rvalid(dmRvalid), .dm_rdata(dmRdata),
    .sram_cs(sramCs), .sram_we(sramWe), .sram_addr(sramAddr), .sram_din(sramDin),
    .sram_dout(sramDout), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(14), .RD_LAT(3)) dutB (
    .clk(clk), .rst(rst),
    .if_req(ifReqB), .if_addr(ifAddrB), .if_gnt(ifGntB), .if_rvalid(ifRvalidB), .if_rdata(ifRdataB),
    .dm_req(dmReqB), .dm_we(dmWeB), .dm_addr(dmAddrB), .dm_wdata(dmWdataB), .dm_gnt(dmGntB),
    .dm_rvalid(dmRvalidB), .dm_rdata(dmRdataB),
    .sram_cs(sramCsB), .sram_we(sramWeB), .sram_addr(sramAddrB), .sram_din(sramDinB),
    .sram_dout(sramDoutB), .busy(busyB)
  );

  function automatic logic [31:0] pattern(input logic [13:0] a);
    return {8'hA5, 2'b00, a, ~a[7:0]};
  endfunction

  // SRAM models: read data is a function of the word address and is only
  // valid in the cycle the configured latency says; otherwise it is junk.
  always @(posedge clk) begin
    rdA  <= {sramCs && (sramWe == 4'b0000), pattern(sramAddr)};
    rdB0 <= {sramCsB && (sramWeB == 4'b0000), pattern(sramAddrB)};
    rdB1 <= rdB0;
    rdB2 <= rdB1;
  end
  assign sramDout  = rdA[32]  ? rdA[31:0]  : 32'h0BAD_F00D;
  assign sramDoutB = rdB2[32] ? rdB2[31:0] : 32'h0BAD_F00D;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Raises a request and records the read data it should eventually return.
  task automatic applyStimulus(input logic toIf, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic expectResp);
    if (toIf) begin
      ifReq  = 1'b1;
      ifAddr = addr;
      if (expectResp) ifQ.push_back(pattern(addr[15:2]));
    end else begin
      dmReq   = 1'b1;
      dmWe    = we;
      dmAddr  = addr;
      dmWdata = wdata;
      if (expectResp && we == 4'b0000) dmQ.push_back(pattern(addr[15:2]));
    end
  endtask

  task automatic waitGrant(input logic toIf, input int budget, input string tag);
    logic got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = toIf ? ifGnt : dmGnt;
    end
    checkOutput(tag, {31'h0, got}, 32'h1);
  endtask

  // Scoreboard side: every rvalid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (ifRvalid) begin
      if (ifQ.size() == 0) checkOutput("if_rvalid_unexpected", 32'h1, 32'h0);
      else checkOutput("if_rdata", ifRdata, ifQ.pop_front());
    end
    if (dmRvalid) begin
      if (dmQ.size() == 0) checkOutput("dm_rvalid_unexpected", 32'h1, 32'h0);
      else checkOutput("dm_rdata", dmRdata, dmQ.pop_front());
    end
    if (ifRvalidB) begin
      if (ifQB.size() == 0) checkOutput("b_if_rvalid_unexpected", 32'h1, 32'h0);
      else checkOutput("b_if_rdata", ifRdataB, ifQB.pop_front());
    end
    if (dmRvalidB) begin
      if (dmQB.size() == 0) checkOutput("b_dm_rvalid_unexpected", 32'h1, 32'h0);
      else checkOutput("b_dm_rdata", dmRdataB, dmQB.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   grants;
    logic expectDm;
    logic saw;

    rst = 1'b1;
    ifReq = 1'b1; ifAddr = 32'h0; dmReq = 1'b0; dmWe = 4'h0; dmAddr = 32'h0; dmWdata = 32'h0;
    ifReqB = 1'b0; ifAddrB = 32'h0; dmReqB = 1'b1; dmWeB = 4'h0; dmAddrB = 32'h0; dmWdataB = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_if_gnt", ifGnt, 0);
    checkOutput("rst_b_dm_gnt", dmGntB, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cs", sramCs, 0);
    checkOutput("rst_we", sramWe, 0);
    checkOutput("rst_addr", sramAddr, 0);
    checkOutput("rst_din", sramDin, 0);
    checkOutput("rst_rvalid", {ifRvalid, dmRvalid}, 0);
    checkOutput("rst_rdata", ifRdata | dmRdata, 0);
    checkOutput("rst_b_busy", busyB, 0);

    // Fetch read at latency 1
    @(posedge clk); #1 rst = 1'b0; ifReq = 1'b0; dmReqB = 1'b0;
    @(posedge clk); #1 applyStimulus(1'b1, 4'h0, 32'h10, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t1_if_gnt", ifGnt, 1);
    checkOutput("t1_dm_gnt", dmGnt, 0);
    checkOutput("t1_busy_grant", busy, 0);
    @(posedge clk); #1 ifReq = 1'b0;
    @(negedge clk);
    checkOutput("t1_cs", sramCs, 1);
    checkOutput("t1_addr", sramAddr, 4);
    checkOutput("t1_we", sramWe, 0);
    checkOutput("t1_busy", busy, 1);
    @(negedge clk);
    checkOutput("t1_cs_off", sramCs, 0);
    checkOutput("t1_rvalid_early", ifRvalid, 0);
    @(negedge clk);
    checkOutput("t1_rvalid", ifRvalid, 1);
    checkOutput("t1_dm_rvalid", dmRvalid, 0);
    checkOutput("t1_busy_done", busy, 0);
    @(negedge clk);
    checkOutput("t1_rvalid_pulse", ifRvalid, 0);
    checkOutput("t1_rdata_hold", ifRdata, pattern(14'd4));

    // Data write, then a fetch granted two cycles after the write grant
    @(posedge clk); #1 applyStimulus(1'b0, 4'b0011, 32'h20, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    checkOutput("t2_dm_gnt", dmGnt, 1);
    checkOutput("t2_if_gnt", ifGnt, 0);
    @(posedge clk); #1 dmReq = 1'b0; dmWe = 4'h0; applyStimulus(1'b1, 4'h0, 32'h40, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t2_cs", sramCs, 1);
    checkOutput("t2_we", sramWe, 4'b0011);
    checkOutput("t2_addr", sramAddr, 8);
    checkOutput("t2_din", sramDin, 32'hDEADBEEF);
    checkOutput("t2_if_gnt_cmd", ifGnt, 0);
    @(negedge clk);
    checkOutput("t2_if_gnt_next", ifGnt, 1);
    checkOutput("t2_cs_off", sramCs, 0);
    checkOutput("t2_we_off", sramWe, 0);
    @(posedge clk); #1 ifReq = 1'b0;
    repeat (4) @(negedge clk);

    // Both requesters held: grants must alternate starting with IF
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ifReq = 1'b1; ifAddr = 32'h100; dmReq = 1'b1; dmWe = 4'h0; dmAddr = 32'h200;
    grants = 0;
    expectDm = 1'b0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      @(negedge clk);
      if (ifGnt || dmGnt) begin
        checkOutput("t3_single_gnt", {31'h0, ifGnt & dmGnt}, 0);
        checkOutput("t3_order_dm", {31'h0, dmGnt}, {31'h0, expectDm});
        if (ifGnt) ifQ.push_back(pattern(14'h40));
        else dmQ.push_back(pattern(14'h80));
        expectDm = ~expectDm;
        grants++;
      end
    end
    checkOutput("t3_grant_count", grants, 6);
    @(posedge clk); #1 ifReq = 1'b0; dmReq = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while waiting on read data discards the transaction
    @(posedge clk); #1 applyStimulus(1'b1, 4'h0, 32'h300, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t4_if_gnt", ifGnt, 1);
    @(posedge clk); #1 ifReq = 1'b0;
    @(negedge clk);
    checkOutput("t4_busy_cmd", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    ifReq = 1'b1; ifAddr = 32'h80; dmReq = 1'b1; dmWe = 4'h0; dmAddr = 32'h84;
    @(negedge clk);
    checkOutput("t4_gnt_in_wait", {ifGnt, dmGnt}, 0);
    @(negedge clk);
    checkOutput("t4_rvalid", {ifRvalid, dmRvalid}, 0);
    checkOutput("t4_gnt_rst", {ifGnt, dmGnt}, 0);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_cs_we", {sramCs, sramWe}, 0);
    checkOutput("t4_addr", sramAddr, 0);
    checkOutput("t4_din", sramDin, 0);
    checkOutput("t4_if_rdata", ifRdata, 0);
    checkOutput("t4_dm_rdata", dmRdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    ifQ.push_back(pattern(14'h20));
    dmQ.push_back(pattern(14'h21));
    @(negedge clk);
    checkOutput("t4_first_if", ifGnt, 1);
    checkOutput("t4_first_dm", dmGnt, 0);
    @(posedge clk); #1 ifReq = 1'b0;
    waitGrant(1'b0, 10, "t4_dm_gnt_timeout");
    @(posedge clk); #1 dmReq = 1'b0;
    repeat (5) @(negedge clk);

    // Fetch pulse while busy is dropped without a grant or an SRAM access
    @(posedge clk); #1 applyStimulus(1'b0, 4'h0, 32'h400, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("t5_dm_gnt", dmGnt, 1);
    @(posedge clk); #1 dmReq = 1'b0; ifReq = 1'b1; ifAddr = 32'h500;
    @(negedge clk);
    checkOutput("t5_if_gnt_busy", ifGnt, 0);
    @(posedge clk); #1 ifReq = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (sramCs || ifGnt) saw = 1'b1;
    end
    checkOutput("t5_no_access", {31'h0, saw}, 0);
    @(posedge clk); #1
    applyStimulus(1'b1, 4'h0, 32'h600, 32'h0, 1'b1);
    applyStimulus(1'b0, 4'h0, 32'h604, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t5_ptr_if", ifGnt, 1);
    checkOutput("t5_ptr_dm", dmGnt, 0);
    @(posedge clk); #1 ifReq = 1'b0; dmReq = 1'b0;
    repeat (4) @(negedge clk);

    // Data read at latency 3 on the second instance
    @(posedge clk); #1 dmReqB = 1'b1; dmWeB = 4'h0; dmAddrB = 32'h200; dmQB.push_back(pattern(14'h80));
    @(negedge clk);
    checkOutput("t6_dm_gnt", dmGntB, 1);
    checkOutput("t6_busy_grant", busyB, 0);
    @(posedge clk); #1 dmReqB = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("t6_busy", busyB, 1);
      checkOutput("t6_cs", {31'h0, sramCsB}, (k == 1) ? 32'h1 : 32'h0);
      checkOutput("t6_rvalid_early", dmRvalidB, 0);
    end
    @(negedge clk);
    checkOutput("t6_rvalid", dmRvalidB, 1);
    checkOutput("t6_if_rvalid", ifRvalidB, 0);
    checkOutput("t6_busy_done", busyB, 0);
    repeat (2) @(negedge clk);

    checkOutput("sb_if_left", ifQ.size(), 0);
    checkOutput("sb_dm_left", dmQ.size(), 0);
    checkOutput("sb_b_dm_left", dmQB.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
